// File: rtl/hm_ctrl_pkg.sv
// Shared definitions for the hm CPU control unit: opcodes, ALU codes, FSM states
// and the decoded-instruction record.
package hm_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_IMM  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       is_mem;
        logic       mem_we;
        logic       is_jmp;
        logic       is_jz;
        logic       is_out;
        logic       is_hlt;
        logic       illegal;
    } dec_t;

    // Opcodes that need a second memory transfer for their operand
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ);
    endfunction

endpackage

// File: rtl/hm_opcode_decoder.sv
// Combinational opcode decoder: turns the instruction's opcode nibble into
// the control flags the sequencer acts on.
module hm_opcode_decoder
    import hm_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.is_mem = is_mem_op(opcode);
        dec.is_jmp = is_jump(opcode) && (opcode != OP_JZ);
        dec.is_jz  = (opcode == OP_JZ);
        dec.is_out = (opcode == OP_OUT);
        dec.is_hlt = (opcode == OP_HLT);
        case (opcode)
            OP_ADD:  dec.alu_op = ALU_ADD;
            OP_SUB:  dec.alu_op = ALU_SUB;
            OP_STA:  dec.mem_we = 1'b1;
            OP_OUT:  dec.alu_op = ALU_PASS;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: dec.illegal = 1'b1;
            default: dec.alu_op = ALU_IMM;
        endcase
    end

endmodule

// File: rtl/hm_sequencer.sv
// Control unit of the hm 8-bit CPU: fetch/decode/execute/writeback FSM owning
// the shared memory port. Optional single-step mode via HM_SINGLE_STEP_EN.
module hm_sequencer
    import hm_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
`ifdef HM_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [ADDR_W-1:0] pc_value,
    input  logic              zero_flag,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              pc_jmp,
    output logic [ADDR_W-1:0] pc_jmploc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        alu_op,
    output logic              acc_we,
    output logic              out_we,
    output logic              halted,
    output logic              bus_err,
    output logic              illegal
);

    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;
    logic [TO_W-1:0]   to_cnt;
    logic              zf_q;
    logic              waiting;
    logic              timeout;
    logic              jump_now;
    logic [3:0]        opcode;
    dec_t              dec;

    assign opcode = ir[DATA_W-1 -: 4];

    hm_opcode_decoder u_dec (
        .opcode (opcode),
        .dec    (dec)
    );

`ifdef HM_SINGLE_STEP_EN
    localparam state_t RETIRE_ST = ST_PAUSE;
    logic step_q;
    logic step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end

    assign step_rise = step & ~step_q;
`else
    localparam state_t RETIRE_ST = ST_FETCH;
`endif

    // A completing ack always wins over a timeout in the same cycle
    assign waiting  = (state == ST_FETCH) || (state == ST_MEM);
    assign timeout  = (ACK_TIMEOUT != 0) && waiting && !mem_ack &&
                      (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign jump_now = dec.is_jmp || (dec.is_jz && zero_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ir      <= '0;
            to_cnt  <= '0;
            zf_q    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state  <= state_next;
            to_cnt <= (waiting && !mem_ack) ? to_cnt + TO_W'(1) : '0;
            if ((state == ST_FETCH) && mem_ack) ir <= mem_rdata;
            if (state == ST_DECODE) zf_q <= zero_flag;
            if (timeout) bus_err <= 1'b1;
        end
    end

    // The datapath captures the ADD/SUB operand from mem_rdata on mem_ack
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        pc_jmp     = 1'b0;
        pc_jmploc  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        alu_op     = ALU_IMM;
        acc_we     = 1'b0;
        out_we     = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_IDLE: if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
                if (mem_ack)      state_next = ST_DECODE;
                else if (timeout) state_next = ST_HALT;
            end
            ST_DECODE: begin
                pc_en      = !(jump_now || dec.is_hlt);
                illegal    = dec.illegal;
                state_next = dec.is_mem ? ST_MEM : ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_hlt) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = RETIRE_ST;
                    acc_we     = (opcode == OP_LDI);
                    out_we     = dec.is_out;
                    if (dec.is_jmp || (dec.is_jz && zf_q)) begin
                        pc_jmp    = 1'b1;
                        pc_jmploc = ir[ADDR_W-1:0];
                    end
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = dec.mem_we;
                mem_addr = ir[ADDR_W-1:0];
                if (mem_ack)      state_next = dec.mem_we ? RETIRE_ST : ST_WB;
                else if (timeout) state_next = ST_HALT;
            end
            ST_WB: begin
                acc_we     = 1'b1;
                alu_op     = dec.alu_op;
                state_next = RETIRE_ST;
            end
            ST_HALT: halted = 1'b1;
`ifdef HM_SINGLE_STEP_EN
            ST_PAUSE: if (step_rise) state_next = ST_FETCH;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hm_sequencer.sv
// Self-checking bench for hm_sequencer: an ISA-level model predicts per-instruction
// strobe counts, memory traffic and halting; also covers timeout and async reset.
module tb_hm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, zero_flag, mem_ack;
    logic [3:0] pc_value;
    logic [7:0] mem_rdata;
`ifdef HM_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic       pc_en, pc_jmp, mem_req, mem_we, acc_we, out_we, halted, bus_err, illegal;
    logic [3:0] pc_jmploc, mem_addr;
    logic [1:0] alu_op;

    hm_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
`ifdef HM_SINGLE_STEP_EN
        .step      (step),
`endif
        .pc_value  (pc_value),
        .zero_flag (zero_flag),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_en     (pc_en),
        .pc_jmp    (pc_jmp),
        .pc_jmploc (pc_jmploc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .alu_op    (alu_op),
        .acc_we    (acc_we),
        .out_we    (out_we),
        .halted    (halted),
        .bus_err   (bus_err),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    int n_pc_en = 0, n_pc_jmp = 0, n_acc_we = 0, n_out_we = 0, n_illegal = 0, n_both = 0;
    logic [1:0] last_alu = 2'b00;
    logic [3:0] last_loc = 4'h0;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (pc_en)  n_pc_en++;
        if (pc_jmp) begin n_pc_jmp++; last_loc = pc_jmploc; end
        if (acc_we) begin n_acc_we++; last_alu = alu_op; end
        if (out_we) n_out_we++;
        if (illegal) n_illegal++;
        if (pc_en && pc_jmp) n_both++;
    end

    logic [7:0] img [16];
    logic [3:0] m_pc;
    logic [7:0] m_acc;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output(tag, {pc_en, pc_jmp, pc_jmploc, mem_req, mem_we, mem_addr, alu_op,
                           acc_we, out_we, halted, bus_err, illegal}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        pc_value = 4'h0; zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");
        m_pc = 4'h0; m_acc = 8'h00;
    endtask

    task automatic start();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Memory responder: wait for a request, check it, ack after a random delay
    task automatic serve(input logic [3:0] addr, input logic we, input logic [7:0] data, input string tag);
        int n = 0;
        while (!mem_req && n < 40) begin @(negedge clk); n++; end
        check_output({tag, "_req"}, mem_req, 1);
        if (mem_req) begin
            check_output({tag, "_addr"}, mem_addr, addr);
            check_output({tag, "_we"}, mem_we, we);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_ack = 1'b1; mem_rdata = data;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 8'h00;
        end
    endtask

    task automatic exec_instr();
        logic [3:0] op, arg;
        logic       taken;
        int s_en, s_jmp, s_acc, s_out, s_ill, n;
        op  = img[m_pc][7:4];
        arg = img[m_pc][3:0];
        pc_value  = m_pc;
        zero_flag = (m_acc == 8'h00);
        #1;
        s_en = n_pc_en; s_jmp = n_pc_jmp; s_acc = n_acc_we; s_out = n_out_we; s_ill = n_illegal;
        taken = (op == 4'h5) || (op == 4'h6 && m_acc == 8'h00);
        serve(m_pc, 1'b0, img[m_pc], "fetch");
        if (op == 4'h2 || op == 4'h3 || op == 4'h4)
            serve(arg, op == 4'h4, img[arg], "operand");
`ifdef HM_SINGLE_STEP_EN
        repeat (6) @(negedge clk);
        check_output("pause_no_req", mem_req, 0);
        if (op != 4'hF) begin
            step = 1'b1; @(negedge clk); step = 1'b0;
        end
`endif
        n = 0;
        while (!mem_req && !halted && n < 20) begin @(negedge clk); n++; end
        check_output("halt_state", halted, op == 4'hF);
        check_output("pc_en_count", n_pc_en - s_en, (taken || op == 4'hF) ? 0 : 1);
        check_output("pc_jmp_count", n_pc_jmp - s_jmp, taken);
        check_output("acc_we_count", n_acc_we - s_acc, op == 4'h1 || op == 4'h2 || op == 4'h3);
        check_output("out_we_count", n_out_we - s_out, op == 4'h7);
        check_output("illegal_count", n_illegal - s_ill, op >= 4'h8 && op <= 4'hE);
        if (op == 4'h1 || op == 4'h2 || op == 4'h3)
            check_output("alu_op", last_alu, (op == 4'h2) ? 2'd1 : (op == 4'h3) ? 2'd2 : 2'd0);
        if (taken) check_output("jmploc", last_loc, arg);
        case (op)
            4'h1: m_acc = {4'h0, arg};
            4'h2: m_acc = m_acc + img[arg];
            4'h3: m_acc = m_acc - img[arg];
            default: ;
        endcase
        if (op != 4'hF) m_pc = taken ? arg : m_pc + 4'h1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, s_en;
        $display("[TB] start");
        do_reset();

        // Directed program: LDI/ADD/JZ not taken/SUB/LDI 0/JZ taken/illegal/OUT/STA/NOP/JMP/HLT
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        img[0] = 8'h13; img[1] = 8'h2A; img[2] = 8'h63; img[3] = 8'h3A;
        img[4] = 8'h10; img[5] = 8'h67; img[7] = 8'h91; img[8] = 8'h70;
        img[9] = 8'h4B; img[10] = 8'h05; img[11] = 8'h5C; img[12] = 8'hF0;
        start();
        for (int i = 0; i < 12; i++) exec_instr();
        s_en = n_pc_en;
        repeat (2) begin mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0; @(negedge clk); end
        check_output("hlt_ignores_ack", {halted, mem_req}, 2'b10);
        check_output("hlt_no_pc_en", n_pc_en - s_en, 0);

        // Reset in the middle of a store transfer
        do_reset();
        img[0] = 8'h45;
        start();
        pc_value = 4'h0; zero_flag = 1'b0; #1;
        serve(4'h0, 1'b0, 8'h45, "sta_fetch");
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        check_output("sta_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 4'h5});
        #2 rst_n = 1'b0;
        #1 check_output("async_drop", {mem_req, mem_we}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle_after_async");
        repeat (3) @(negedge clk);
        check_output("stays_idle", mem_req, 0);

        // Random program against the ISA model (no HLT)
        do_reset();
        for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom);
            if (img[i][7:4] == 4'hF) img[i][7:4] = 4'h0;
        end
        start();
        for (int i = 0; i < 40; i++) exec_instr();

        // Fetch with no ack: bus error after the timeout window
        do_reset();
        start();
        n = 0;
        while (mem_req && n < 40) begin n++; @(negedge clk); end
        check_output("timeout_len", n, 15);
        check_output("bus_err", bus_err, 1);
        check_output("timeout_halted", halted, 1);
        s_en = n_pc_en;
        repeat (3) begin
            mem_ack = 1'b1; mem_rdata = 8'h13; @(negedge clk);
            mem_ack = 1'b0; @(negedge clk);
        end
        check_output("late_ack_req", mem_req, 0);
        check_output("late_ack_state", {halted, bus_err}, 2'b11);
        check_output("late_ack_pc_en", n_pc_en - s_en, 0);

        check_output("en_jmp_exclusive", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
